// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity modes.
// Both ends of the link import this package so frame formats stay in lockstep.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Mode 3 is reserved and behaves exactly like PARITY_NONE.
  function automatic logic parity_enabled(input int mode);
    return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a registered
// falling-edge detector on the synchronized line.
module uart_rx_sync (
  input  logic rx_clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic fall_q,  fall_d;

  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fall_d  = prev_q & ~sync2_q;
  end

  // Line flops reset to the idle-high level so reset release never looks like an edge.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values;
      // blocking here would collapse the synchronizer chain into one stage.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fall_q  <= fall_d;
    end
  end

  assign rx_s       = sync2_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop frame recovery with a
// one-cycle data_valid strobe and parity/frame error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int data_width = 8,
  parameter int test       = 2,
  parameter int stop_width = 1,
  parameter int oversample = 16
) (
  input  logic                  rx_clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  output logic [data_width-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int             CW        = $clog2(oversample);
  localparam logic [CW-1:0]  HALF_LAST = CW'(oversample / 2 - 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(oversample - 1);
  localparam logic [3:0]     DATA_LAST = 4'(data_width - 1);
  localparam logic [3:0]     STOP_LAST = 4'(stop_width - 1);
  localparam logic           PAR_EN    = parity_enabled(test);

  logic rx_s;
  logic fall_pulse;

  uart_rx_sync u_sync (
    .rx_clk     (rx_clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .rx_s       (rx_s),
    .fall_pulse (fall_pulse)
  );

  uart_state_e           state_q,      state_d;
  logic [CW-1:0]         cnt_q,        cnt_d;
  logic [3:0]            bit_idx_q,    bit_idx_d;
  logic [data_width-1:0] shift_q,      shift_d;
  logic                  par_bit_q,    par_bit_d;
  logic                  ferr_stk_q,   ferr_stk_d;
  logic [data_width-1:0] data_out_q,   data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q,  frame_err_d;
  logic                  busy_q,       busy_d;

  logic exp_par;
  logic at_half;
  logic at_end;

  always_comb begin
    exp_par = (test == PARITY_ODD) ? ~^shift_q : ^shift_q;
    at_half = (cnt_q == HALF_LAST);
    at_end  = (cnt_q == CNT_LAST);

    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    ferr_stk_d   = ferr_stk_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        if (fall_pulse) begin
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        cnt_d = cnt_q + CW'(1);
        if (at_half) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (at_end) begin
          cnt_d     = '0;
          shift_d   = (shift_q >> 1) | (data_width'(rx_s) << (data_width - 1));
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = PAR_EN ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (at_end) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end

      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (at_end) begin
          cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            // Deliver mid-stop-bit so a back-to-back start edge is still seen.
            data_out_d   = shift_q;
            parity_err_d = PAR_EN && (par_bit_q != exp_par);
            frame_err_d  = ferr_stk_q | ~rx_s;
            data_valid_d = 1'b1;
            ferr_stk_d   = 1'b0;
            bit_idx_d    = '0;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            ferr_stk_d = ferr_stk_q | ~rx_s;
            bit_idx_d  = bit_idx_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the shift register is reset along with everything else; it is a
  // handful of flops, not a memory, and a clean start state is cheap here.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      ferr_stk_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      ferr_stk_q   <= ferr_stk_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default parameters (8 data bits, even parity,
// 1 stop bit, 16x oversampling): frames are queued as driven, checked on data_valid.
module tb_uart_rx;

  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int SW  = 1;
  localparam int P   = 1;
  localparam int LAT = 2 + OS / 2 + (DW + P + SW) * OS + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    int            cyc;
  } exp_t;

  logic          rx_clk;
  logic          rst_n;
  logic          rx_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   cycle_cnt;
  int   last_valid_cyc;
  int   prev_valid_cyc;

  uart_rx #(
    .data_width (DW),
    .test       (2),
    .stop_width (SW),
    .oversample (OS)
  ) dut (
    .rx_clk     (rx_clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  always @(posedge rx_clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle_cnt);
    end
  endtask

  // Scoreboard consumer: every data_valid must match the oldest queued frame.
  always @(negedge rx_clk) begin
    if (rst_n && data_valid) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cycle_cnt;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(data_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_out",   32'(data_out),   32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
        check("frame_err",  32'(frame_err),  32'(e.ferr));
        check("valid_cycle", 32'(cycle_cnt), 32'(e.cyc));
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (OS) @(negedge rx_clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = (par != ^d);
    e.ferr = ~stop;
    e.cyc  = cycle_cnt + 1 + LAT;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * OS) @(negedge rx_clk);
  endtask

  initial begin
    logic [DW-1:0] f0;
    logic          saw_busy;
    total          = 0;
    bad            = 0;
    cycle_cnt      = 0;
    last_valid_cyc = 0;
    prev_valid_cyc = 0;
    rst_n          = 1'b0;
    rx_in          = 1'b1;
    repeat (3) @(negedge rx_clk);

    check("rst_data_out",   32'(data_out),   32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Clean frame, correct even parity.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);

    // False start: short low glitch.
    saw_busy = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(negedge rx_clk);
    rx_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge rx_clk);
      if (busy) saw_busy = 1'b1;
    end
    check("false_start_busy_seen", 32'(saw_busy),   32'd1);
    check("false_start_busy_end",  32'(busy),       32'd0);
    check("false_start_data",      32'(data_out),   32'hA5);
    check("false_start_perr",      32'(parity_err), 32'd0);

    // Parity error, then a good frame clears it.
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(2);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);

    // Frame error followed by a long break: exactly one delivery, no retrigger.
    send_frame(8'h55, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (40 * OS) @(negedge rx_clk);
    check("break_no_busy", 32'(busy), 32'd0);
    idle_bits(3);

    // Back-to-back frames with a single stop bit between them.
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    idle_bits(2);
    check("b2b_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'(11 * OS));

    // Reset in the middle of data bit 4 of 0xF0.
    f0 = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(f0[i]);
    rx_in = f0[4];
    repeat (OS / 2) @(negedge rx_clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_out",   32'(data_out),   32'd0);
    check("mid_rst_data_valid", 32'(data_valid), 32'd0);
    check("mid_rst_parity_err", 32'(parity_err), 32'd0);
    check("mid_rst_frame_err",  32'(frame_err),  32'd0);
    check("mid_rst_busy",       32'(busy),       32'd0);
    repeat (4) @(negedge rx_clk);
    rst_n = 1'b1;
    idle_bits(4);
    check("post_rst_idle", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(2);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge rx_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
